// File: rtl/tl_ul_inflight_tracker.sv
// TL-UL in-flight request tracker: per-source outstanding table with protocol
// error detection (bad opcode, duplicate source, orphan/mismatched response, timeout).
module tl_ul_inflight_tracker #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned NSRC    = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         a_valid,
  input  logic                         a_ready,
  input  logic [2:0]                   a_opcode,
  input  logic [2:0]                   a_size,
  input  logic [1:0]                   a_source,
  input  logic                         d_valid,
  input  logic                         d_ready,
  input  logic [2:0]                   d_opcode,
  input  logic [2:0]                   d_size,
  input  logic [1:0]                   d_source,
  output logic [NSRC-1:0]              inflight,
  output logic [$clog2(NSRC+1)-1:0]    outstanding_cnt,
  output logic                         err_bad_opcode,
  output logic                         err_dup_source,
  output logic                         err_orphan_d,
  output logic                         err_mismatch,
  output logic                         err_timeout,
  output logic                         err_sticky
);

  localparam int unsigned CNT_W = $clog2(NSRC + 1);
  localparam logic [7:0]  TO8   = 8'(TIMEOUT);

  typedef struct packed {
    logic       busy;
    logic       exp_data;
    logic [2:0] size;
    logic [7:0] age;
  } entry_t;

  entry_t ent_q [NSRC];
  entry_t ent_d [NSRC];

  logic             a_fire;
  logic             d_fire;
  logic             a_op_ok;
  logic             alloc;
  logic             bad_d;
  logic             dup_d;
  logic             orphan_d;
  logic             mm_d;
  logic             to_d;
  logic [NSRC-1:0]  busy_d;
  logic [CNT_W-1:0] cnt_d;

  assign a_fire  = a_valid & a_ready;
  assign d_fire  = d_valid & d_ready;
  assign a_op_ok = (a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4);
  assign alloc   = a_fire & a_op_ok;

  // Next table state: D retires first, then aging, then A allocates.
  always_comb begin
    for (int i = 0; i < int'(NSRC); i++) ent_d[i] = ent_q[i];
    bad_d    = 1'b0;
    dup_d    = 1'b0;
    orphan_d = 1'b0;
    mm_d     = 1'b0;
    to_d     = 1'b0;
    busy_d   = '0;
    cnt_d    = '0;

    if (d_fire) begin
      if (ent_q[d_source].busy) begin
        ent_d[d_source].busy = 1'b0;
        if ((d_opcode != {2'b00, ent_q[d_source].exp_data}) ||
            (d_size != ent_q[d_source].size))
          mm_d = 1'b1;
      end else begin
        orphan_d = 1'b1;
      end
    end

    if (a_fire && !a_op_ok) bad_d = 1'b1;

    // Age survivors; the saturated-age guard keeps the timeout a single pulse.
    for (int i = 0; i < int'(NSRC); i++) begin
      if (ent_d[i].busy && !(alloc && (2'(i) == a_source))) begin
        if (ent_q[i].age != 8'hFF) ent_d[i].age = ent_q[i].age + 8'd1;
        if ((ent_d[i].age == TO8) && (ent_q[i].age != TO8)) to_d = 1'b1;
      end
    end

    if (alloc) begin
      if (ent_d[a_source].busy) dup_d = 1'b1;
      ent_d[a_source] = '{busy: 1'b1, exp_data: (a_opcode == 3'd4),
                          size: a_size, age: 8'd0};
    end

    for (int i = 0; i < int'(NSRC); i++) begin
      busy_d[i] = ent_d[i].busy;
      cnt_d     = cnt_d + CNT_W'(ent_d[i].busy);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NSRC); i++) ent_q[i] <= '0;
      inflight        <= '0;
      outstanding_cnt <= '0;
      err_bad_opcode  <= 1'b0;
      err_dup_source  <= 1'b0;
      err_orphan_d    <= 1'b0;
      err_mismatch    <= 1'b0;
      err_timeout     <= 1'b0;
      err_sticky      <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NSRC); i++) ent_q[i] <= ent_d[i];
      inflight        <= busy_d;
      outstanding_cnt <= cnt_d;
      err_bad_opcode  <= bad_d;
      err_dup_source  <= dup_d;
      err_orphan_d    <= orphan_d;
      err_mismatch    <= mm_d;
      err_timeout     <= to_d;
      err_sticky      <= err_sticky | bad_d | dup_d | orphan_d | mm_d | to_d;
    end
  end

endmodule

// File: tb/tb_tl_ul_inflight_tracker.sv
// Directed bench for tl_ul_inflight_tracker: a deadline-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_tl_ul_inflight_tracker;

  localparam int unsigned TO = 10;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       a_valid, a_ready, d_valid, d_ready;
  logic [2:0] a_opcode, a_size, d_opcode, d_size;
  logic [1:0] a_source, d_source;
  logic [3:0] inflight;
  logic [2:0] outstanding_cnt;
  logic       err_bad_opcode, err_dup_source, err_orphan_d, err_mismatch;
  logic       err_timeout, err_sticky;

  always #5 clock = ~clock;

  tl_ul_inflight_tracker #(.TIMEOUT(TO), .NSRC(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_size(a_size), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_size(d_size), .d_source(d_source),
    .inflight(inflight), .outstanding_cnt(outstanding_cnt),
    .err_bad_opcode(err_bad_opcode), .err_dup_source(err_dup_source),
    .err_orphan_d(err_orphan_d), .err_mismatch(err_mismatch),
    .err_timeout(err_timeout), .err_sticky(err_sticky)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: outstanding set with a per-request deadline cycle.
  bit       m_busy [4];
  bit       m_get  [4];
  int       m_sz   [4];
  int       m_dl   [4];
  int       cyc = 0;
  bit       m_bad, m_dup, m_orph, m_mm, m_to, m_sticky;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit nb [4];
    bit af, df, ok;
    int as, ds;
    af = a_valid && a_ready;
    df = d_valid && d_ready;
    as = int'(a_source);
    ds = int'(d_source);
    {m_bad, m_dup, m_orph, m_mm, m_to} = '0;
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) m_busy[i] = 0;
      m_sticky = 0;
    end else begin
      nb = m_busy;
      if (df) begin
        if (m_busy[ds]) begin
          nb[ds] = 0;
          if (int'(d_opcode) != (m_get[ds] ? 1 : 0) || int'(d_size) != m_sz[ds]) m_mm = 1;
        end else m_orph = 1;
      end
      ok = (a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4);
      if (af && !ok) m_bad = 1;
      for (int i = 0; i < 4; i++)
        if (m_busy[i] && nb[i] && !(af && ok && i == as) && cyc == m_dl[i]) m_to = 1;
      if (af && ok) begin
        if (nb[as]) m_dup = 1;
        nb[as] = 1;
        m_get[as] = (a_opcode == 3'd4);
        m_sz[as] = int'(a_size);
        m_dl[as] = cyc + int'(TO);
      end
      m_busy = nb;
      m_sticky = m_sticky | m_bad | m_dup | m_orph | m_mm | m_to;
    end
    cyc++;
  endtask

  task automatic compare_all();
    int ei, ec;
    ei = 0; ec = 0;
    for (int i = 0; i < 4; i++) if (m_busy[i]) begin ei += (1 << i); ec++; end
    check("inflight", int'(inflight), ei);
    check("outstanding_cnt", int'(outstanding_cnt), ec);
    check("err_bad_opcode", int'(err_bad_opcode), int'(m_bad));
    check("err_dup_source", int'(err_dup_source), int'(m_dup));
    check("err_orphan_d", int'(err_orphan_d), int'(m_orph));
    check("err_mismatch", int'(err_mismatch), int'(m_mm));
    check("err_timeout", int'(err_timeout), int'(m_to));
    check("err_sticky", int'(err_sticky), int'(m_sticky));
  endtask

  task automatic step(input logic rst, input logic av, input logic ar,
                      input logic [2:0] aop, input logic [2:0] asz, input logic [1:0] asrc,
                      input logic dv, input logic [2:0] dop, input logic [2:0] dsz,
                      input logic [1:0] dsrc);
    reset_n = rst; a_valid = av; a_ready = ar; a_opcode = aop; a_size = asz;
    a_source = asrc; d_valid = dv; d_ready = 1'b1; d_opcode = dop; d_size = dsz;
    d_source = dsrc;
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0);
  endtask
  task automatic a_req(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src);
    step(1'b1, 1'b1, 1'b1, op, sz, src, 1'b0, 3'd0, 3'd0, 2'd0);
  endtask
  task automatic d_rsp(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src);
    step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 2'd0, 1'b1, op, sz, src);
  endtask

  initial begin
    int to_cnt, to_at;
    for (int i = 0; i < 4; i++) begin m_busy[i] = 0; m_get[i] = 0; m_sz[i] = 0; m_dl[i] = -1; end
    m_sticky = 0;
    {m_bad, m_dup, m_orph, m_mm, m_to} = '0;

    // Reset state
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0);
    check("lit_reset_inflight", int'(inflight), 0);
    check("lit_reset_sticky", int'(err_sticky), 0);

    // Get src2 size2, AccessAckData three cycles later
    a_req(3'd4, 3'd2, 2'd2);
    check("lit_get2_c1", int'(inflight), 4);
    idle();
    check("lit_get2_c2", int'(inflight), 4);
    idle();
    check("lit_get2_c3", int'(inflight), 4);
    d_rsp(3'd1, 3'd2, 2'd2);
    check("lit_get2_done", int'(inflight), 0);
    check("lit_get2_noerr", int'(err_sticky), 0);

    // PutFull src1 answered with AccessAckData -> mismatch
    a_req(3'd0, 3'd3, 2'd1);
    d_rsp(3'd1, 3'd3, 2'd1);
    check("lit_mm_pulse", int'(err_mismatch), 1);
    check("lit_mm_sticky", int'(err_sticky), 1);
    check("lit_mm_inflight", int'(inflight), 0);
    idle();
    check("lit_mm_onecycle", int'(err_mismatch), 0);

    // Same-source A and D in one cycle: retire then reallocate, no dup
    a_req(3'd4, 3'd2, 2'd0);
    step(1'b1, 1'b1, 1'b1, 3'd4, 3'd2, 2'd0, 1'b1, 3'd1, 3'd2, 2'd0);
    check("lit_same_inflight0", int'(inflight[0]), 1);
    check("lit_same_nodup", int'(err_dup_source), 0);
    d_rsp(3'd1, 3'd2, 2'd0);

    // Orphan D, then bad opcode
    d_rsp(3'd1, 3'd0, 2'd1);
    check("lit_orphan", int'(err_orphan_d), 1);
    a_req(3'd2, 3'd0, 2'd1);
    check("lit_bad_opcode", int'(err_bad_opcode), 1);
    check("lit_bad_inflight", int'(inflight), 0);

    // A held off by a_ready=0 is not a fire
    step(1'b1, 1'b1, 1'b0, 3'd4, 3'd1, 2'd2, 1'b0, 3'd0, 3'd0, 2'd0);
    check("lit_noready", int'(inflight), 0);

    // Timeout: Get src3 with no response
    a_req(3'd4, 3'd0, 2'd3);
    to_cnt = 0; to_at = -1;
    for (int j = 1; j <= 13; j++) begin
      idle();
      if (err_timeout) begin to_cnt++; to_at = j; end
    end
    check("lit_timeout_count", to_cnt, 1);
    check("lit_timeout_cycle", to_at, 10);
    check("lit_timeout_busy", int'(inflight[3]), 1);
    d_rsp(3'd1, 3'd0, 2'd3);

    // Duplicate source overwrites the entry; new size/opcode are what's checked
    a_req(3'd4, 3'd1, 2'd1);
    a_req(3'd0, 3'd2, 2'd1);
    check("lit_dup", int'(err_dup_source), 1);
    d_rsp(3'd0, 3'd2, 2'd1);
    check("lit_dup_resp_ok", int'(err_mismatch), 0);

    // Simultaneous errors: orphan D plus bad opcode
    step(1'b1, 1'b1, 1'b1, 3'd7, 3'd0, 2'd0, 1'b1, 3'd0, 3'd0, 2'd2);
    check("lit_multi_bad", int'(err_bad_opcode), 1);
    check("lit_multi_orph", int'(err_orphan_d), 1);

    // Different sources in the same cycle
    a_req(3'd1, 3'd2, 2'd1);
    step(1'b1, 1'b1, 1'b1, 3'd4, 3'd3, 2'd0, 1'b1, 3'd0, 3'd2, 2'd1);
    check("lit_diff_inflight", int'(inflight), 1);
    d_rsp(3'd1, 3'd3, 2'd0);

    // Fill all four, then reset (with an A fire that must be ignored)
    a_req(3'd4, 3'd0, 2'd0);
    a_req(3'd4, 3'd0, 2'd1);
    a_req(3'd4, 3'd0, 2'd2);
    a_req(3'd4, 3'd0, 2'd3);
    check("lit_full_cnt", int'(outstanding_cnt), 4);
    step(1'b0, 1'b1, 1'b1, 3'd4, 3'd0, 2'd2, 1'b0, 3'd0, 3'd0, 2'd0);
    check("lit_rst_cnt", int'(outstanding_cnt), 0);
    check("lit_rst_sticky", int'(err_sticky), 0);
    d_rsp(3'd1, 3'd0, 2'd0);
    check("lit_post_rst_orphan", int'(err_orphan_d), 1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
